motor_pwm_generator: RTL and testbench
======================================

Name: motor_pwm_generator

Overview:
- Consumes the 8-bit `motor_total_offset` produced by `motor_offset_summer` (nominal 50 = hover) and drives one motor ESC with a PWM signal.
- Interprets the input as duty in percent (0..100). Values above 100 are clamped.
- Duty is latched only at period boundaries, so each period is glitch-free.
- An arming state machine keeps the output safe until it is explicitly armed.

Parameters:
- STEP_DIV, 1000, clock cycles per duty step (prescaler terminal count). Must be ≥1.
- ARM_DUTY, 5, duty percent driven while arming.
- ARM_PERIODS, 50, number of full PWM periods spent in ARMING before ARMED.
- SLEW_MAX, 4, maximum duty change per period in percent. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- motor_total_offset  input  8  unsigned requested duty in percent, from `motor_offset_summer`
- arm  input  1  level; 1 requests arming, 0 disarms
- pwm_out  output  1  ESC PWM drive
- period_start  output  1  one-cycle pulse at step 0 of every period
- armed  output  1  high only in state ARMED
- duty_active  output  7  duty (0..100) in effect for the current period
- clamped  output  1  high when the value latched this period was >100

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - pwm_out=0, period_start=0, armed=0, duty_active=0, clamped=0.
  - Prescaler=0, step counter=0, arming period counter=0, state=DISARMED.
- **Timebase:**
  - The prescaler counts 0..STEP_DIV-1. On its terminal count it issues a step tick and wraps to 0.
  - The step counter advances on each tick, 0..99, then wraps to 0.
  - One period = 100*STEP_DIV clocks.
  - The timebase runs continuously in all states after reset.
- **Period boundary:** the cycle in which the step counter wraps 99→0, plus the first cycle after reset release.
  - period_start=1 for exactly that one cycle.
  - duty_active loads the new target: min(motor_total_offset,100) in ARMED, ARM_DUTY in ARMING, 0 in DISARMED.
  - clamped loads (motor_total_offset>100) in ARMED, else 0.
  - Input changes mid-period have no effect until the next boundary.
- **Output:**
  - pwm_out is registered: pwm_out = (step < duty_active).
  - Duty 0 gives constant 0; duty 100 gives constant 1.
  - High time = duty_active*STEP_DIV clocks, starting at step 0.
- **State machine:**
  - DISARMED: arm=1 sampled at a period boundary → ARMING; the arming period counter clears to 0.
  - ARMING: the counter increments at each boundary. When it reaches ARM_PERIODS at a boundary → ARMED; that boundary already loads the ARMED duty.
  - ARMED: armed=1.
  - arm=0 in ARMING or ARMED, at any cycle → DISARMED immediately. On the next clock, pwm_out=0, duty_active=0, armed=0. Safety takes priority over period alignment.
  - Re-arming restarts the full ARM_PERIODS sequence.
- **Simultaneous events:** arm falling in the same cycle as a boundary → DISARMED wins; duty loads 0.
- **Arithmetic:** compare against the unsigned 8-bit input. Negative summer results arrive as large unsigned values (≥128) and are clamped to 100.
- **Reset mid-period:** all state is abandoned immediately. No partial pulse completes.

Optional Feature:
- Macro: `MOTOR_PWM_SLEW_LIMIT_EN`.
- **Defined:** in ARMED, the duty_active load at each boundary is limited to within ±SLEW_MAX of the previous duty_active.
  - The ARMING→ARMED transition starts from ARM_DUTY.
  - clamped still reflects only the input.
  - Disarm still forces 0 immediately.
- **Undefined:** duty_active jumps directly to the clamped target.

Test Plan:
All tests use STEP_DIV=2, ARM_PERIODS=2, ARM_DUTY=5.
1. **Reset values:** hold rst_n=0 for 5 cycles → all outputs 0. After release, period_start pulses every 200 clocks.
2. **Arming sequence:** arm=1, input 55.
   - ARMING periods: pwm_out high 10 of 200 clocks.
   - After 2 periods: armed=1 and high 110 of 200 clocks (duty_active=55).
3. **Mid-period change:** armed, input changes 55→70 at step 30 → current period keeps 110 clocks high; next period 140 clocks high.
4. **Clamp:** input 8'hF6 (−10) → duty_active=100, clamped=1, pwm_out constant 1. Input 101 → same result.
5. **Immediate disarm:** arm→0 at step 20 with duty 70 → pwm_out=0 and armed=0 one clock later; output stays 0 in following periods.
6. **Slew limit (`MOTOR_PWM_SLEW_LIMIT_EN` defined, SLEW_MAX=4):** armed at duty 10, input steps to 70 → duty_active sequence 14, 18, 22, … over successive periods. Input back to 10 → decrements by 4 per period.

Source files
------------

// File: rtl/motor_pwm_generator.sv
// motor_pwm_generator: percent-duty ESC PWM with period-aligned duty latching and an arming state machine
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   motor_total_offset  requested duty in percent (unsigned, >100 clamped to 100)
//   arm                 level; 1 requests arming, 0 disarms immediately
//   pwm_out             registered PWM drive, high while step < duty_active
//   period_start        one-cycle pulse at step 0 of every period
//   armed               high only in ARMED
//   duty_active         duty in effect for the current period
//   clamped             request latched this period exceeded 100
// Optional: define MOTOR_PWM_SLEW_LIMIT_EN to limit the armed duty change per period to SLEW_MAX.
module motor_pwm_generator #(
  parameter int STEP_DIV    = 1000,
  parameter int ARM_DUTY    = 5,
  parameter int ARM_PERIODS = 50
`ifdef MOTOR_PWM_SLEW_LIMIT_EN
  , parameter int SLEW_MAX  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] motor_total_offset,
  input  logic       arm,
  output logic       pwm_out,
  output logic       period_start,
  output logic       armed,
  output logic [6:0] duty_active,
  output logic       clamped
);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int AW = (ARM_PERIODS > 0) ? $clog2(ARM_PERIODS + 1) : 1;
  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;
  state_t        r_state;
  state_t        w_ns;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_step;
  logic [AW-1:0] r_arm_cnt;
  logic [AW-1:0] w_cnt_inc;
  logic [6:0]    r_duty;
  logic          r_pwm;
  logic          r_ps;
  logic          r_armed;
  logic          r_clamped;
  logic          w_tick;
  logic          w_bnd;
  logic          w_over;
  logic [6:0]    w_sat;
  logic [6:0]    w_tgt;
  logic [6:0]    w_duty_nxt;
  logic          w_clamp_nxt;
  assign w_tick    = r_presc == PW'(STEP_DIV - 1);
  // Counters at 0/0 mark both the first cycle after reset and the cycle right after each 99->0 wrap.
  assign w_bnd     = (r_step == 7'd0) && (r_presc == '0);
  assign w_over    = motor_total_offset > 8'd100;
  assign w_sat     = w_over ? 7'd100 : motor_total_offset[6:0];
  assign w_cnt_inc = r_arm_cnt + 1'b1;
`ifdef MOTOR_PWM_SLEW_LIMIT_EN
  logic [7:0] w_base;
  logic [7:0] w_hi;
  logic [7:0] w_lo;
  assign w_base = (r_state == ARMING) ? 8'(ARM_DUTY) : {1'b0, r_duty};
  assign w_hi   = w_base + 8'(SLEW_MAX);
  assign w_lo   = (w_base > 8'(SLEW_MAX)) ? w_base - 8'(SLEW_MAX) : 8'd0;
  assign w_tgt  = ({1'b0, w_sat} > w_hi) ? w_hi[6:0] :
                  ({1'b0, w_sat} < w_lo) ? w_lo[6:0] : w_sat;
`else
  assign w_tgt  = w_sat;
`endif
  // Disarm overrides everything, including a coincident period boundary.
  assign w_ns = !arm                   ? DISARMED :
                !w_bnd                 ? r_state  :
                (r_state == DISARMED)  ? ARMING   :
                (r_state == ARMED || w_cnt_inc >= AW'(ARM_PERIODS)) ? ARMED : ARMING;
  // The duty loaded at a boundary follows the state being entered, so the arming
  // boundary already drives ARM_DUTY and the final one already drives the request.
  assign w_duty_nxt  = !arm              ? 7'd0 :
                       !w_bnd            ? r_duty :
                       (w_ns == ARMED)   ? w_tgt :
                       (w_ns == ARMING)  ? 7'(ARM_DUTY) : 7'd0;
  assign w_clamp_nxt = !arm ? 1'b0 : !w_bnd ? r_clamped : (w_ns == ARMED) && w_over;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_step    <= '0;
      r_arm_cnt <= '0;
      r_state   <= DISARMED;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
      r_ps      <= 1'b0;
      r_armed   <= 1'b0;
      r_clamped <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_step    <= !w_tick ? r_step : (r_step == 7'd99) ? 7'd0 : r_step + 7'd1;
      r_arm_cnt <= (r_state == DISARMED) ? '0 :
                   (w_bnd && r_state == ARMING) ? w_cnt_inc : r_arm_cnt;
      r_state   <= w_ns;
      r_duty    <= w_duty_nxt;
      r_pwm     <= r_step < w_duty_nxt;
      r_ps      <= w_bnd;
      r_armed   <= w_ns == ARMED;
      r_clamped <= w_clamp_nxt;
    end
  end
  assign pwm_out      = r_pwm;
  assign period_start = r_ps;
  assign armed        = r_armed;
  assign duty_active  = r_duty;
  assign clamped      = r_clamped;
endmodule

// File: tb/tb_motor_pwm_generator.sv
// tb_motor_pwm_generator: randomized check of motor_pwm_generator against a period-level reference model
module tb_motor_pwm_generator;
  localparam int SD  = 2;
  localparam int AD  = 5;
  localparam int AP  = 2;
  localparam int PER = 100 * SD;
`ifdef MOTOR_PWM_SLEW_LIMIT_EN
  localparam int SM  = 4;
`endif
  logic       clk = 0;
  logic       rst_n = 1;
  logic       arm = 0;
  logic [7:0] off = 0;
  logic       pwm_out;
  logic       period_start;
  logic       armed;
  logic [6:0] duty_active;
  logic       clamped;
  always #5 clk = ~clk;
  motor_pwm_generator #(.STEP_DIV(SD), .ARM_DUTY(AD), .ARM_PERIODS(AP)) dut (
    .clk(clk), .rst_n(rst_n), .motor_total_offset(off), .arm(arm),
    .pwm_out(pwm_out), .period_start(period_start), .armed(armed),
    .duty_active(duty_active), .clamped(clamped)
  );
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;
  int cnt = 0;
  int m_duty = 0;
  int hi_cnt = 0;
  int per_duty = 0;
  bit m_pwm = 0;
  bit m_ps = 0;
  bit m_clamp = 0;
  bit clean = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic check_outputs();
    check("pwm_out", pwm_out, m_pwm);
    check("period_start", period_start, m_ps);
    check("armed", armed, mode == 2);
    check("duty_active", duty_active, m_duty);
    check("clamped", clamped, m_clamp);
  endtask
  // Timebase is derived arithmetically from the cycle count since reset release;
  // mode 0/1/2 = disarmed/arming/armed.
  task automatic model_edge();
    int step, tgt, base, prev;
    bit bnd;
    if (!rst_n) return;
    step = (cyc / SD) % 100;
    bnd  = (cyc % PER) == 0;
    prev = mode;
    if (bnd) begin
      if (clean) check("high_time", hi_cnt, per_duty * SD);
      hi_cnt = 0;
      clean = 1;
    end
    m_ps = bnd;
    if (!arm) begin
      if (mode != 0 && !bnd) clean = 0;
      mode = 0;
      m_duty = 0;
      m_clamp = 0;
    end else if (bnd) begin
      if (mode == 0) begin
        mode = 1;
        cnt = 0;
      end else if (mode == 1) begin
        cnt++;
        if (cnt >= AP) mode = 2;
      end
      tgt = (off > 100) ? 100 : int'(off);
`ifdef MOTOR_PWM_SLEW_LIMIT_EN
      base = (prev == 1) ? AD : m_duty;
      if (tgt > base + SM) tgt = base + SM;
      else if (tgt < base - SM) tgt = base - SM;
`else
      base = prev;
`endif
      m_duty  = (mode == 2) ? tgt : (mode == 1) ? AD : 0;
      m_clamp = (mode == 2) && (off > 100);
    end
    if (bnd) per_duty = m_duty;
    m_pwm = step < m_duty;
    cyc++;
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (rst_n) hi_cnt += int'(pwm_out);
    check_outputs();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_phase(input int ph);
    int k = 0;
    while (cyc % PER != ph) begin
      tick();
      k++;
      if (k > PER) begin
        check("wait_phase_timeout", k, 0);
        return;
      end
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 0;
    #1;
    mode = 0;
    cnt = 0;
    m_duty = 0;
    m_pwm = 0;
    m_ps = 0;
    m_clamp = 0;
    clean = 0;
    cyc = 0;
    hi_cnt = 0;
    check_outputs();
    run(n);
    rst_n = 1;
  endtask
  function automatic logic [7:0] pick_off();
    logic [7:0] edges [7] = '{8'd0, 8'd99, 8'd100, 8'd101, 8'd127, 8'd128, 8'd255};
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 255));
      1: return 8'($urandom_range(0, 100));
      default: return edges[$urandom_range(0, 6)];
    endcase
  endfunction
  initial begin
    #2;
    do_reset(5);
    run(3 * PER);
    arm = 1;
    off = 8'd55;
    run(4 * PER);
    wait_phase(60);
    off = 8'd70;
    run(2 * PER);
    off = 8'hF6;
    run(2 * PER);
    off = 8'd101;
    run(PER);
    off = 8'd100;
    run(PER);
    off = 8'd0;
    run(PER);
    off = 8'd70;
    run(PER);
    wait_phase(40);
    arm = 0;
    run(2 * PER);
    arm = 1;
    run(4 * PER);
    wait_phase(0);
    arm = 0;
    run(PER);
`ifdef MOTOR_PWM_SLEW_LIMIT_EN
    arm = 1;
    off = 8'd10;
    run(6 * PER);
    off = 8'd70;
    run(16 * PER);
    off = 8'd10;
    run(16 * PER);
`endif
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 4));
      arm = $urandom_range(0, 9) != 0;
      off = pick_off();
      run($urandom_range(1, 600));
    end
    wait_phase(0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
